// File: rtl/shared_div_ctrl.sv
// Round-robin arbiter in front of one shared restoring divider (one quotient bit per cycle).
// Define SHARED_DIV_ROUND_EN to round the quotient to nearest (remainder reported unrounded).
module shared_div_ctrl #(
    parameter int N    = 18,
    parameter int REQS = 4,
    localparam int IW  = (REQS > 1) ? $clog2(REQS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQS-1:0]    req,
    input  logic [REQS*N-1:0]  dividend,
    input  logic [REQS*N-1:0]  divisor,
    output logic [REQS-1:0]    gnt,
    output logic               busy,
    output logic               done,
    output logic [IW-1:0]      done_id,
    output logic [N-1:0]       quotient,
    output logic [N-1:0]       remainder,
    output logic               div_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    state_t         state_next;

    logic [IW-1:0]  last_grant;
    logic [IW-1:0]  sel_id;
    logic [IW-1:0]  cur_id;
    logic           sel_valid;
    logic           grant_fire;
    logic [N-1:0]   sel_dividend;
    logic [N-1:0]   sel_divisor;
    int             idx;

    logic [N:0]     pr;
    logic [N-1:0]   dq;
    logic [N-1:0]   dv;
    logic [CW-1:0]  cnt;

    logic [N:0]     trial;
    logic [N:0]     diff;
    logic           qbit;
    logic [N:0]     pr_next;
    logic [N-1:0]   dq_next;
    logic [N-1:0]   q_final;

    // Scan from last_grant+1 upwards; descending loop so the closest requester wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        idx       = 0;
        for (int k = REQS - 1; k >= 0; k--) begin
            idx = (int'(last_grant) + 1 + k) % REQS;
            if (req[idx]) begin
                sel_valid = 1'b1;
                sel_id    = IW'(idx);
            end
        end
    end

    always_comb begin
        sel_dividend = dividend[sel_id*N +: N];
        sel_divisor  = divisor[sel_id*N +: N];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant is gated by rst_n so it drops the instant reset is asserted.
    always_comb begin
        state_next = state;
        gnt        = '0;
        busy       = 1'b0;
        done       = 1'b0;
        grant_fire = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid && rst_n) begin
                    gnt[sel_id] = 1'b1;
                    grant_fire  = 1'b1;
                    state_next  = (sel_divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial   = (pr << 1) | (N+1)'(dq[N-1]);
        diff    = trial - {1'b0, dv};
        qbit    = (trial >= {1'b0, dv});
        pr_next = qbit ? diff : trial;
        dq_next = (dq << 1) | N'(qbit);
    end

`ifdef SHARED_DIV_ROUND_EN
    always_comb begin
        q_final = dq_next;
        if (({pr_next[N-1:0], 1'b0} >= {1'b0, dv}) && (dq_next != '1)) begin
            q_final = dq_next + N'(1);
        end
    end
`else
    always_comb begin
        q_final = dq_next;
    end
`endif

    // Results are loaded on the edge entering DONE so they are visible alongside the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IW'(REQS - 1);
            cur_id     <= '0;
            pr         <= '0;
            dq         <= '0;
            dv         <= '0;
            cnt        <= '0;
            done_id    <= '0;
            quotient   <= '0;
            remainder  <= '0;
            div_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        last_grant <= sel_id;
                        cur_id     <= sel_id;
                        if (sel_divisor == '0) begin
                            quotient  <= '1;
                            remainder <= sel_dividend;
                            div_zero  <= 1'b1;
                            done_id   <= sel_id;
                        end else begin
                            pr  <= '0;
                            dq  <= sel_dividend;
                            dv  <= sel_divisor;
                            cnt <= '0;
                        end
                    end
                end
                CALC: begin
                    pr  <= pr_next;
                    dq  <= dq_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        quotient  <= q_final;
                        remainder <= pr_next[N-1:0];
                        div_zero  <= 1'b0;
                        done_id   <= cur_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_div_ctrl.sv
// Scoreboard bench for shared_div_ctrl: a timing/arithmetic model predicts grants and results,
// a negedge monitor compares whatever the DUT presents.
module tb_shared_div_ctrl;

    localparam int N    = 18;
    localparam int REQS = 4;
    localparam int IW   = 2;

    typedef struct {
        int           id;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REQS-1:0]   req;
    logic [REQS*N-1:0] dividend;
    logic [REQS*N-1:0] divisor;
    logic [REQS-1:0]   gnt;
    logic              busy;
    logic              done;
    logic [IW-1:0]     done_id;
    logic [N-1:0]      quotient;
    logic [N-1:0]      remainder;
    logic              div_zero;

    logic [N-1:0]      op_a [REQS];
    logic [N-1:0]      op_b [REQS];

    exp_t              sb [$];
    int                cyc = 0;
    int                checks = 0;
    int                fails = 0;
    int                last_model = REQS - 1;
    int                next_free = 0;
    int                grant_count = 0;
    int                mode = 0;
    logic [N-1:0]      hold_div;
    logic [REQS-1:0]   granted_mask = '0;

    for (genvar g = 0; g < REQS; g++) begin : pack
        assign dividend[g*N +: N] = op_a[g];
        assign divisor[g*N +: N]  = op_b[g];
    end

    shared_div_ctrl #(.N(N), .REQS(REQS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .dividend  (dividend),
        .divisor   (divisor),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    function automatic int model_pick(input logic [REQS-1:0] r, input int last);
        for (int k = 1; k <= REQS; k++) begin
            if (r[(last + k) % REQS]) return (last + k) % REQS;
        end
        return -1;
    endfunction

    function automatic void model_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                      output logic [N-1:0] q, output logic [N-1:0] r,
                                      output logic dz);
        int ai;
        int bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = N'(ai / bi);
            r  = N'(ai % bi);
            dz = 1'b0;
`ifdef SHARED_DIV_ROUND_EN
            if (2 * (ai % bi) >= bi && (ai / bi) < (1 << N) - 1) q = N'(ai / bi + 1);
`endif
        end
    endfunction

    function automatic logic [N-1:0] rand_divisor();
        logic [N-1:0] v;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = N'(1);
            2: v = N'($urandom_range(1, 15));
            default: begin
                v = N'($urandom);
                if (v == '0) v = N'(7);
            end
        endcase
        return v;
    endfunction

    // Monitor: predicts grant/busy from the transaction-level model and scores every done.
    always @(negedge clk) begin : monitor
        int              pick;
        logic [REQS-1:0] exp_gnt;
        logic            exp_done;
        exp_t            e;
        if (rst_n) begin
            checkOutput("busy", 32'(busy), 32'(cyc < next_free));
            exp_gnt = '0;
            pick    = -1;
            if (cyc >= next_free) pick = model_pick(req, last_model);
            if (pick >= 0) exp_gnt[pick] = 1'b1;
            checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
            granted_mask = exp_gnt;
            if (pick >= 0) begin
                model_div(op_a[pick], op_b[pick], e.q, e.r, e.dz);
                e.id  = pick;
                e.cyc = cyc + ((op_b[pick] == '0) ? 1 : N + 1);
                sb.push_back(e);
                last_model = pick;
                next_free  = e.cyc + 1;
                grant_count++;
            end
            exp_done = (sb.size() > 0) && (sb[0].cyc == cyc);
            checkOutput("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                e = sb.pop_front();
                checkOutput("done_id", 32'(done_id), 32'(e.id));
                checkOutput("quotient", 32'(quotient), 32'(e.q));
                checkOutput("remainder", 32'(remainder), 32'(e.r));
                checkOutput("div_zero", 32'(div_zero), 32'(e.dz));
            end
        end
    end

    task automatic new_ops(input int i, input logic [N-1:0] b);
        op_a[i] = N'($urandom);
        op_b[i] = b;
    endtask

    // Advance one cycle and react to the grant the monitor saw before this edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        for (int i = 0; i < REQS; i++) begin
            if (granted_mask[i]) begin
                case (mode)
                    0: req[i] = 1'b0;
                    1: new_ops(i, hold_div);
                    default: begin
                        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                        else new_ops(i, rand_divisor());
                    end
                endcase
            end
        end
        granted_mask = '0;
        if (mode == 2) begin
            for (int i = 0; i < REQS; i++) begin
                if (!req[i] && $urandom_range(0, 4) == 0) begin
                    new_ops(i, rand_divisor());
                    req[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && req == '0 && cyc >= next_free) break;
            applyStimulus();
        end
        checkOutput("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_grants(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (grant_count >= target) break;
            applyStimulus();
        end
        checkOutput("grant_wait", 32'(grant_count >= target), 32'd1);
    endtask

    task automatic single(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        mode    = 0;
        op_a[i] = a;
        op_b[i] = b;
        req[i]  = 1'b1;
        wait_idle(100);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g0;
        rst_n    = 1'b0;
        req      = '1;
        hold_div = N'(3);
        for (int i = 0; i < REQS; i++) new_ops(i, N'(5));
        #3;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_done_id", 32'(done_id), 32'd0);
        checkOutput("rst_quotient", 32'(quotient), 32'd0);
        checkOutput("rst_remainder", 32'(remainder), 32'd0);
        checkOutput("rst_div_zero", 32'(div_zero), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        req   = '0;
        rst_n = 1'b1;

        $display("[TB] all requesters held, divisor 3");
        mode = 1;
        for (int i = 0; i < REQS; i++) new_ops(i, hold_div);
        req = '1;
        g0  = grant_count;
        wait_grants(g0 + 5, 200);
        req  = '0;
        mode = 0;
        wait_idle(100);

        $display("[TB] directed divisions");
        single(0, N'(100000), N'(2));
        checkOutput("held_q_100000_2", 32'(quotient), 32'd50000);
        checkOutput("held_r_100000_2", 32'(remainder), 32'd0);
        single(1, N'(12345), N'(0));
        checkOutput("held_q_div0", 32'(quotient), 32'd262143);
        checkOutput("held_r_div0", 32'(remainder), 32'd12345);
        checkOutput("held_dz_div0", 32'(div_zero), 32'd1);
        checkOutput("held_id_div0", 32'(done_id), 32'd1);
        single(2, N'(7), N'(2));
`ifdef SHARED_DIV_ROUND_EN
        checkOutput("held_q_7_2", 32'(quotient), 32'd4);
`else
        checkOutput("held_q_7_2", 32'(quotient), 32'd3);
`endif
        checkOutput("held_r_7_2", 32'(remainder), 32'd1);
        single(3, N'(262143), N'(1));
        checkOutput("held_q_max_1", 32'(quotient), 32'd262143);
        checkOutput("held_r_max_1", 32'(remainder), 32'd0);

        $display("[TB] reset during calculation");
        mode    = 0;
        op_a[0] = N'(9999);
        op_b[0] = N'(5);
        req[0]  = 1'b1;
        g0      = grant_count;
        wait_grants(g0 + 1, 50);
        applyStimulus();
        op_a[2] = N'(4321);
        op_b[2] = N'(10);
        req[2]  = 1'b1;
        repeat (4) applyStimulus();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        checkOutput("mid_rst_gnt", 32'(gnt), 32'd0);
        checkOutput("mid_rst_quotient", 32'(quotient), 32'd0);
        sb.delete();
        last_model   = REQS - 1;
        next_free    = 0;
        granted_mask = '0;
        repeat (2) applyStimulus();
        rst_n = 1'b1;
        g0    = grant_count;
        wait_grants(g0 + 1, 10);
        checkOutput("post_rst_first_id", 32'(last_model), 32'd2);
        wait_idle(100);

        $display("[TB] randomized traffic");
        mode = 2;
        repeat (1500) applyStimulus();
        mode = 0;
        req  = '0;
        wait_idle(200);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/shared_div_ctrl.md
SHARED_DIV_CTRL -- requirements
Module: shared_div_ctrl

Interface
REQ-001 Parameter N, default 18, operand and result width in bits.
REQ-002 Parameter REQS, default 4, number of requesters; IW = $clog2(REQS), minimum 1.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; ports SHALL be as listed in REQ-004 to REQ-014.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  REQS  per-requester division request, level, held until granted.
REQ-007 dividend  in  REQS*N  packed dividends, requester i at bits [i*N +: N].
REQ-008 divisor  in  REQS*N  packed divisors, same packing as dividend.
REQ-009 gnt  out  REQS  one-hot grant, 1-cycle pulse, operands captured that cycle.
REQ-010 busy  out  1  high from the cycle after grant through the DONE cycle.
REQ-011 done  out  1  1-cycle pulse, result valid.
REQ-012 done_id  out  IW  index of the requester whose result is presented.
REQ-013 quotient, remainder  out  N each  result registers, held until the next done.
REQ-014 div_zero  out  1  result flag, divisor was 0, held with the result.

Function
REQ-015 FSM states SHALL be IDLE, CALC and DONE.
REQ-016 In IDLE with any req high, gnt SHALL combinationally select one requester, round-robin from (last_grant+1) mod REQS.
- The selected operands SHALL be registered at that clock edge.
- last_grant SHALL update to the selected requester.
REQ-017 gnt SHALL be 0 in all states except IDLE, and 0 in IDLE when req==0.
REQ-018 IDLE to CALC on grant with divisor!=0; IDLE to DONE directly on grant with divisor==0.
REQ-019 CALC SHALL run restoring shift-subtract division, one quotient bit per cycle, MSB first, for exactly N cycles, then go to DONE.
- The partial remainder SHALL be N+1 bits wide, with no overflow for any operands.
REQ-020 In DONE, done=1 for exactly one cycle; quotient, remainder, div_zero and done_id SHALL be updated and visible in that cycle; the next state SHALL be IDLE.
REQ-021 Latency: a grant at edge T SHALL produce done at cycle T+N+1; for divisor 0, done SHALL occur at cycle T+1.
REQ-022 Divisor 0 SHALL give quotient all ones, remainder equal to the dividend, and div_zero=1; otherwise div_zero=0.
REQ-023 Without rounding, the result SHALL equal integer truncating division: quotient = dividend/divisor, remainder = dividend%divisor.
REQ-024 No new grant SHALL be issued during CALC or DONE.
- The earliest re-grant is the cycle after DONE.
- Back-to-back requests SHALL therefore cost N+2 cycles each.
REQ-025 A req deasserted before grant SHALL simply not be served; requesters SHALL hold operands stable while req is high and ungranted.
REQ-026 Simultaneous requests SHALL be served one per transaction in round-robin order.
- No requester SHALL wait more than REQS-1 transactions.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE and last_grant = REQS-1, so requester 0 has first priority.
REQ-028 rst_n low SHALL immediately force gnt=0, busy=0, done=0, done_id=0, quotient=0, remainder=0 and div_zero=0.
REQ-029 Reset during CALC or DONE SHALL abandon the division, produce no done pulse, and require a fresh req.

Configuration
REQ-030 Macro SHARED_DIV_ROUND_EN defined: in DONE with divisor!=0, if 2*remainder >= divisor, quotient SHALL be incremented.
- The increment SHALL saturate at all ones.
- Remainder SHALL be reported unrounded.
- Latency SHALL be unchanged.
REQ-031 SHARED_DIV_ROUND_EN undefined: truncating result per REQ-023; no rounding logic SHALL be present.

Verification
REQ-032 N=18, req=0001, dividend0=100000, divisor0=2 -> gnt=0001, done 19 cycles later, quotient=50000, remainder=0, done_id=0, div_zero=0.
REQ-033 req=0010, dividend1=12345, divisor1=0 -> done 1 cycle after grant, quotient=262143, remainder=12345, div_zero=1, done_id=1.
REQ-034 req=1111 held, all divisors 3 -> grants in order 0,1,2,3,0, each done_id matching, grants spaced 20 cycles apart.
REQ-035 dividend=7, divisor=2 -> quotient=3, remainder=1 without SHARED_DIV_ROUND_EN; quotient=4, remainder=1 with it. dividend=262143, divisor=1 -> 262143 in both builds.
REQ-036 rst_n low 5 cycles after a grant -> busy=0 and done=0 immediately, no done pulse; with req=0100 still high after release, gnt=0100 is granted before any other requester.
